// File: rtl/data_sram_like_bridge_pkg.sv
// Shared encodings for the MEM-stage data bridge: FSM states and sram-like bus size codes.
package data_sram_like_bridge_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

endpackage

// File: rtl/data_sram_like_bridge_if.sv
// sram-like data bus: the bridge is the master, the memory system is the slave.
interface data_sram_like_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              data_req;
    logic              data_wr;
    logic [1:0]        data_size;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok;
    logic              data_data_ok;
    logic [DATA_W-1:0] data_rdata;

    modport master (
        output data_req, data_wr, data_size, data_addr, data_wdata,
        input  data_addr_ok, data_data_ok, data_rdata
    );

    modport slave (
        input  data_req, data_wr, data_size, data_addr, data_wdata,
        output data_addr_ok, data_data_ok, data_rdata
    );
endinterface

// File: rtl/data_sram_like_bridge_wen_to_size.sv
// Maps the lane controller's byte write-enable onto the bus direction and transfer size.
module data_sram_like_bridge_wen_to_size
    import data_sram_like_bridge_pkg::*;
(
    input  logic [3:0] mem_wen,
    output logic       wr,
    output logic [1:0] size
);

    // Loads are always full-word; irregular write masks fall back to a word write.
    always_comb begin
        wr = |mem_wen;
        case (mem_wen)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: size = SIZE_B;
            4'b0011, 4'b1100:                   size = SIZE_H;
            default:                            size = SIZE_W;
        endcase
    end

endmodule

// File: rtl/data_sram_like_bridge.sv
// MEM-stage bridge: runs one lane-resolved access as a single-outstanding sram-like
// transaction and stalls the pipeline until it completes.
module data_sram_like_bridge
    import data_sram_like_bridge_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en,
    input  logic [3:0]        mem_wen,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    input  logic              longest_stall,
    output logic              d_stall,
    data_sram_like_bridge_if.master bus
);

    state_t     state;
    logic       wen_wr;
    logic [1:0] wen_size;

    data_sram_like_bridge_wen_to_size u_wen_to_size (
        .mem_wen (mem_wen),
        .wr      (wen_wr),
        .size    (wen_size)
    );

    // Request fields are captured once in IDLE so the bus sees them stable however long addr_ok takes.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= S_IDLE;
            bus.data_req   <= 1'b0;
            bus.data_wr    <= 1'b0;
            bus.data_size  <= SIZE_B;
            bus.data_addr  <= '0;
            bus.data_wdata <= '0;
            mem_rdata      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_en) begin
                        state          <= S_REQ;
                        bus.data_req   <= 1'b1;
                        bus.data_wr    <= wen_wr;
                        bus.data_size  <= wen_size;
                        bus.data_addr  <= wen_wr ? mem_addr : {mem_addr[ADDR_W-1:2], 2'b00};
                        bus.data_wdata <= mem_wdata;
                    end
                end
                S_REQ: begin
                    if (bus.data_addr_ok) begin
                        state        <= S_WAIT;
                        bus.data_req <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.data_data_ok) begin
                        if (!bus.data_wr) begin
                            mem_rdata <= bus.data_rdata;
                        end
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Holding here while MEM is frozen elsewhere keeps the same access from re-issuing.
                    if (!longest_stall) begin
                        state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    always_comb begin
        d_stall = 1'b0;
        if (resetn) begin
            case (state)
                S_IDLE:         d_stall = mem_en;
                S_REQ, S_WAIT:  d_stall = 1'b1;
                S_DONE:         d_stall = 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_sram_like_bridge.sv
// Scoreboard bench for data_sram_like_bridge: a randomized bus slave, a request monitor
// and a spec-level model of request fields, stall length and returned read data.
module tb_data_sram_like_bridge;
    import data_sram_like_bridge_pkg::*;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_en = 1'b0;
    logic [3:0]  mem_wen = 4'h0;
    logic [31:0] mem_addr = 32'h0;
    logic [31:0] mem_wdata = 32'h0;
    logic [31:0] mem_rdata;
    logic        longest_stall = 1'b0;
    logic        d_stall;

    int          tests = 0;
    int          fails = 0;
    req_t        exp_q[$];
    logic [31:0] modelRdata = 32'h0;
    int          addrDelay = 0;
    int          dataDelay = 0;
    bit          slaveOn = 1'b1;
    bit          forceAddrOk = 1'b0;
    bit          forceDataOk = 1'b0;
    logic [31:0] forceRdata = 32'h0;
    bit          curRead = 1'b0;

    data_sram_like_bridge_if bus ();

    data_sram_like_bridge dut (
        .clk           (clk),
        .resetn        (resetn),
        .mem_en        (mem_en),
        .mem_wen       (mem_wen),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_rdata     (mem_rdata),
        .longest_stall (longest_stall),
        .d_stall       (d_stall),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected bus request, derived from the byte-enable rules.
    function automatic req_t model(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata);
        req_t m;
        m.wr = (wen != 4'h0);
        if (!m.wr)                                m.size = SIZE_W;
        else if ($countones(wen) == 1)            m.size = SIZE_B;
        else if (wen == 4'b0011 || wen == 4'b1100) m.size = SIZE_H;
        else                                      m.size = SIZE_W;
        m.addr  = m.wr ? addr : (addr & 32'hFFFF_FFFC);
        m.wdata = wdata;
        return m;
    endfunction

    // Bus slave: accepts after addrDelay extra REQ cycles, responds after dataDelay extra WAIT cycles.
    initial begin
        int phase;
        int cnt;
        logic [31:0] rd;
        phase = 0;
        cnt = 0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'h0;
        forever begin
            @(posedge clk);
            #1;
            bus.data_addr_ok = 1'b0;
            bus.data_data_ok = 1'b0;
            bus.data_rdata = $urandom;
            if (!resetn) begin
                phase = 0;
                modelRdata = 32'h0;
            end else if (!slaveOn) begin
                phase = 0;
                bus.data_addr_ok = forceAddrOk;
                bus.data_data_ok = forceDataOk;
                bus.data_rdata = forceRdata;
            end else begin
                if (phase == 0 && bus.data_req) begin
                    phase = 1;
                    cnt = 0;
                end
                if (phase == 1) begin
                    if (cnt == addrDelay) begin
                        bus.data_addr_ok = 1'b1;
                        phase = 2;
                        cnt = 0;
                    end else begin
                        cnt++;
                    end
                end else if (phase == 2) begin
                    if (cnt == dataDelay) begin
                        rd = $urandom;
                        bus.data_data_ok = 1'b1;
                        bus.data_rdata = rd;
                        if (curRead) modelRdata = rd;
                        phase = 0;
                    end else begin
                        cnt++;
                    end
                end
            end
        end
    end

    // Monitor: every cycle data_req is high the request must match the scoreboard head.
    initial begin
        forever begin
            @(negedge clk);
            if (resetn && bus.data_req) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_req", 32'(bus.data_req), 32'h0);
                end else begin
                    req_t e;
                    e = exp_q[0];
                    checkOutput("req_wr", 32'(bus.data_wr), 32'(e.wr));
                    checkOutput("req_size", 32'(bus.data_size), 32'(e.size));
                    checkOutput("req_addr", bus.data_addr, e.addr);
                    checkOutput("req_wdata", bus.data_wdata, e.wdata);
                    if (bus.data_addr_ok) begin
                        curRead = !e.wr;
                        void'(exp_q.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [3:0] wen, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int aD, input int dD, input int lCycles);
        int stalls;
        int reqs;
        bit done;
        addrDelay = aD;
        dataDelay = dD;
        mem_en    = 1'b1;
        mem_wen   = wen;
        mem_addr  = addr;
        mem_wdata = wdata;
        exp_q.push_back(model(wen, addr, wdata));
        @(negedge clk);
        stalls = d_stall ? 1 : 0;
        reqs = 0;
        @(posedge clk);
        #1;
        mem_en    = 1'b0;
        mem_wen   = 4'($urandom);
        mem_addr  = $urandom;
        mem_wdata = $urandom;
        done = 1'b0;
        for (int n = 0; n < 300 && !done; n++) begin
            @(negedge clk);
            if (d_stall) begin
                stalls++;
                if (bus.data_req) reqs++;
            end else begin
                done = 1'b1;
            end
        end
        if (!done) checkOutput("timeout", 32'(d_stall), 32'h0);
        checkOutput("stall_cycles", 32'(stalls), 32'(aD + dD + 3));
        checkOutput("req_cycles", 32'(reqs), 32'(aD + 1));
        checkOutput("mem_rdata", mem_rdata, modelRdata);
        // A held access stays presented while another source freezes MEM.
        longest_stall = (lCycles > 0);
        mem_en = (lCycles > 0);
        for (int i = 0; i < lCycles; i++) begin
            @(negedge clk);
            checkOutput("done_hold_stall", 32'(d_stall), 32'h0);
            checkOutput("done_hold_rdata", mem_rdata, modelRdata);
            if (i == lCycles - 1) begin
                longest_stall = 1'b0;
                mem_en = 1'b0;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [3:0] wen;
        resetn = 1'b0;
        mem_en = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_d_stall", 32'(d_stall), 32'h0);
        checkOutput("rst_req", 32'(bus.data_req), 32'h0);
        checkOutput("rst_wr", 32'(bus.data_wr), 32'h0);
        checkOutput("rst_size", 32'(bus.data_size), 32'h0);
        checkOutput("rst_addr", bus.data_addr, 32'h0);
        checkOutput("rst_wdata", bus.data_wdata, 32'h0);
        checkOutput("rst_rdata", mem_rdata, 32'h0);
        mem_en = 1'b0;
        resetn = 1'b1;
        @(negedge clk);
        checkOutput("idle_d_stall", 32'(d_stall), 32'h0);
        checkOutput("idle_req", 32'(bus.data_req), 32'h0);
        @(posedge clk);
        #1;

        applyStimulus(4'b0000, 32'h8000_0004, 32'h0000_0000, 0, 0, 0);
        applyStimulus(4'b0100, 32'h8000_0006, 32'h5A5A_5A5A, 0, 0, 0);
        applyStimulus(4'b1100, 32'h0000_0010, 32'hA5A5_1234, 1, 0, 0);
        applyStimulus(4'b0000, 32'h0000_0013, 32'h0000_0000, 0, 1, 0);
        applyStimulus(4'b0000, 32'h2000_0040, 32'h0000_0000, 4, 2, 0);
        applyStimulus(4'b1111, 32'h0000_0044, 32'h1234_5678, 0, 0, 3);
        applyStimulus(4'b0110, 32'h0000_0048, 32'hCAFE_F00D, 1, 1, 1);

        // Reset while the bridge waits for data_ok; a late data_ok must not land anywhere.
        @(negedge clk);
        slaveOn = 1'b0;
        forceAddrOk = 1'b1;
        mem_en = 1'b1;
        mem_wen = 4'h0;
        mem_addr = 32'h0000_0100;
        exp_q.push_back(model(4'h0, 32'h0000_0100, mem_wdata));
        @(negedge clk);
        forceAddrOk = 1'b0;
        mem_en = 1'b0;
        @(negedge clk);
        resetn = 1'b0;
        checkOutput("rst_wait_d_stall", 32'(d_stall), 32'h0);
        @(negedge clk);
        resetn = 1'b1;
        checkOutput("rst_wait_req", 32'(bus.data_req), 32'h0);
        checkOutput("rst_wait_wr", 32'(bus.data_wr), 32'h0);
        checkOutput("rst_wait_size", 32'(bus.data_size), 32'h0);
        checkOutput("rst_wait_addr", bus.data_addr, 32'h0);
        checkOutput("rst_wait_wdata", bus.data_wdata, 32'h0);
        checkOutput("rst_wait_rdata", mem_rdata, 32'h0);
        forceDataOk = 1'b1;
        forceRdata = 32'hBAD0_BAD0;
        @(negedge clk);
        forceDataOk = 1'b0;
        @(negedge clk);
        checkOutput("late_data_ok_rdata", mem_rdata, 32'h0);
        checkOutput("late_data_ok_stall", 32'(d_stall), 32'h0);
        checkOutput("late_data_ok_req", 32'(bus.data_req), 32'h0);
        slaveOn = 1'b1;
        @(posedge clk);
        #1;

        applyStimulus(4'b0000, 32'h0000_0200, 32'h0000_0000, 0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            wen = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
            applyStimulus(wen, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                          $urandom_range(0, 2));
        end

        repeat (2) @(negedge clk);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_sram_like_bridge.md
Name: data_sram_like_bridge

Overview:
- Sits directly downstream of the load/store byte-lane controller, in the MEM stage of the MIPS pipeline.
- Takes the lane-resolved access (enable, 4-bit byte write-enable, address, replicated write data) and runs it as a single-outstanding transaction on the sram-like data bus (req/addr_ok/data_ok).
- Stalls the pipeline until the transaction finishes. Returns the raw read word to the lane controller for extraction.

Parameters:
- ADDR_W, 32, address width (cpu side and bus side).
- DATA_W, 32, data width; fixed to 32 (4 byte lanes).

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- resetn  in  1  synchronous active-low reset, sampled on rising edge of clk.
- mem_en  in  1  MEM-stage access valid (load or store).
- mem_wen  in  4  byte write-enable from lane controller; 0000 = load.
- mem_addr  in  32  byte address.
- mem_wdata  in  32  lane-replicated store data.
- mem_rdata  out  32  captured read word, raw and unextracted.
- longest_stall  in  1  pipeline stall from all other sources (excludes d_stall).
- d_stall  out  1  data-side stall request.
- data_req  out  1  bus request.
- data_wr  out  1  1 = write, 0 = read.
- data_size  out  2  0 = byte, 1 = half, 2 = word.
- data_addr  out  32  bus address.
- data_wdata  out  32  bus write data.
- data_addr_ok  in  1  request accepted this cycle (valid only while data_req=1).
- data_data_ok  in  1  response / write-done this cycle.
- data_rdata  in  32  read data, valid with data_data_ok.

Behaviour:
- Reset (resetn=0 at edge): state=IDLE; data_req, data_wr, data_size, data_addr, data_wdata, mem_rdata all 0. d_stall is forced 0 while resetn=0.
- States: IDLE, REQ, WAIT, DONE. Encoded 2 bits.
- IDLE:
  - d_stall = mem_en (combinational).
  - If mem_en: latch the request registers and go to REQ.
  - data_wr = |mem_wen.
  - Write size from mem_wen: one-hot → 0; 0011 or 1100 → 1; 1111 → 2; any other nonzero pattern → 2.
  - Write address: data_addr = mem_addr unchanged.
  - Read: data_size=2; data_addr = {mem_addr[31:2], 2'b00}.
  - data_wdata = mem_wdata.
- REQ:
  - data_req=1; d_stall=1.
  - On data_addr_ok: go to WAIT; data_req=0 from the next cycle.
  - Request registers are stable for as long as data_req=1.
- WAIT:
  - data_req=0; d_stall=1.
  - On data_data_ok: if read, mem_rdata ← data_rdata; go to DONE.
  - data_data_ok in any state other than WAIT is ignored.
- DONE:
  - d_stall=0; mem_rdata holds its value.
  - If longest_stall=0: go to IDLE next cycle. Otherwise stay in DONE.
  - Staying in DONE prevents re-issuing the same access while another source freezes MEM.
- Latency: minimum 3 stall cycles (IDLE, REQ with same-cycle addr_ok, WAIT with same-cycle data_ok). DONE is the first unstalled cycle.
- mem_rdata is only updated on read completion. Writes leave it unchanged.
- mem_en=0 in IDLE: no transaction, d_stall=0.
- Input changes during REQ/WAIT/DONE are ignored (request already latched).
- resetn=0 mid-transaction: return to IDLE and drop data_req. The bus is assumed reset simultaneously.
- Exactly one outstanding transaction; no pipelining of requests.

Decomposition:
- Shared package/header: state encodings (S_IDLE=0, S_REQ=1, S_WAIT=2, S_DONE=3); size codes (SIZE_B=0, SIZE_H=1, SIZE_W=2).
- Optional sub-module wen_to_size: purely combinational mem_wen → {wr, size}. The rest stays in one module.

Test Plan:
- Load word: mem_en=1, wen=0000, addr=0x8000_0004; addr_ok on the first REQ cycle; data_ok next cycle with rdata=0xDEAD_BEEF → data_addr=0x8000_0004, size=2, wr=0; d_stall high exactly 3 cycles; mem_rdata=0xDEAD_BEEF in DONE.
- Store byte: wen=0100, addr=0x8000_0006, wdata=0x5A5A_5A5A → wr=1, size=0, data_addr=0x8000_0006, data_wdata=0x5A5A_5A5A; mem_rdata unchanged.
- Store half: wen=1100, addr=0x10 → size=1, addr=0x10. Load at addr=0x13 → size=2, addr=0x10.
- Backpressure: addr_ok held low 4 cycles, then data_ok 3 cycles later → data_req high for 5 cycles with stable addr/data; d_stall high for 9 cycles total.
- Foreign stall: longest_stall=1 for 3 cycles after data_ok → state stays DONE, d_stall=0, only one request issued. IDLE follows when longest_stall drops.
- Reset mid-WAIT: resetn=0 for one cycle → all outputs 0, state IDLE. A later data_ok is ignored; the next mem_en starts a fresh request.
